// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg -- shared definitions for the instruction fetch unit.
//   state_t       : fetch FSM state encoding (IDLE, RUN)
//   fetch_entry_t : one queued fetch {pc, instr}
//   PC_W, INST_W, FIFO_DEPTH, PC_STEP : datapath sizing and PC increment
package inst_fetch_pkg;

   localparam int unsigned PC_W       = 8;
   localparam int unsigned INST_W     = 32;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam logic [PC_W-1:0] PC_STEP = 8'd4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo -- small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write din (ignored when full unless a pop happens too)
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard every entry; takes priority over push and pop
//   din, dout  : entry in, head entry out (zero while empty)
//   full,empty : occupancy flags
module fetch_fifo
   import inst_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   fetch_entry_t     mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is allowed when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch -- sequential instruction fetch unit with a 2-entry output queue.
// Ports:
//   Clk, Rst_N       : clock, asynchronous active-low reset
//   Fetch_En         : fetching permitted while high
//   Redirect_Valid   : flush queue and load Redirect_Addr into the PC
//   Redirect_Addr    : redirect target byte address
//   Mem_Addr         : instruction memory address (the PC)
//   Mem_Data         : instruction word for Mem_Addr (combinational)
//   Inst_Valid/Ready : head-of-queue handshake
//   Inst_Out, Inst_PC: head instruction and its address
//   Misalign_Err     : sticky misaligned-redirect flag, only present when
//                      INST_FETCH_MISALIGN_EN is defined; otherwise redirect
//                      targets are forced word-aligned.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst_N,
   input  logic              Fetch_En,
   input  logic              Redirect_Valid,
   input  logic [PC_W-1:0]   Redirect_Addr,
   output logic [PC_W-1:0]   Mem_Addr,
   input  logic [INST_W-1:0] Mem_Data,
   output logic              Inst_Valid,
   input  logic              Inst_Ready,
   output logic [INST_W-1:0] Inst_Out,
   output logic [PC_W-1:0]   Inst_PC
`ifdef INST_FETCH_MISALIGN_EN
   ,
   output logic              Misalign_Err
`endif
);

   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

   state_t          state;
   state_t          state_next;
   logic            fetch_active;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] redirect_target;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // State register
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; redirects do not affect the state
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (Fetch_En)  state_next = RUN;
         RUN:     if (!Fetch_En) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: a fetch is attempted only in RUN with no redirect pending
   always_comb begin
      fetch_active = 1'b0;
      if (state == RUN && Fetch_En && !Redirect_Valid) fetch_active = 1'b1;
   end

   assign pop  = ~empty & Inst_Ready;
   assign push = fetch_active & (~full | pop);

`ifdef INST_FETCH_MISALIGN_EN
   assign redirect_target = Redirect_Addr;

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N)
         Misalign_Err <= 1'b0;
      else if (Redirect_Valid && (Redirect_Addr[1:0] != 2'b00))
         Misalign_Err <= 1'b1;
   end
`else
   assign redirect_target = Redirect_Addr & ALIGN_MASK;
`endif

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N)              pc <= '0;
      else if (Redirect_Valid) pc <= redirect_target;
      else if (push)           pc <= pc + PC_STEP;
   end

   assign push_entry = '{pc: pc, instr: Mem_Data};

   fetch_fifo u_fifo (
      .clk   (Clk),
      .rst_n (Rst_N),
      .push  (push),
      .pop   (pop),
      .flush (Redirect_Valid),
      .din   (push_entry),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign Mem_Addr   = pc;
   assign Inst_Valid = ~empty;
   assign Inst_Out   = head.instr;
   assign Inst_PC    = head.pc;

endmodule
